// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, 1-cycle-latency I-Mem reads and a 2-entry skid FIFO toward decode.
// Optional: define FETCH_PERF_CNT_EN to add saturating fetch/stall performance counters.
module instr_fetch_unit #(
  parameter int                  INSTR_WIDTH = 32,
  parameter int                  PC_WIDTH    = 9,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   halt_req,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   imem_rd_en,
  input  logic [INSTR_WIDTH-1:0] imem_dout,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic                   halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            fetch_cnt,
  output logic [31:0]            stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   infl_q, infl_d;
  logic [PC_WIDTH-1:0]    tag_q, tag_d;
  // Head entry drives the outputs directly; skid entry holds the second slot.
  logic                   hd_v_q, hd_v_d;
  logic [INSTR_WIDTH-1:0] hd_data_q, hd_data_d;
  logic [PC_WIDTH-1:0]    hd_pc_q, hd_pc_d;
  logic                   sk_v_q, sk_v_d;
  logic [INSTR_WIDTH-1:0] sk_data_q, sk_data_d;
  logic [PC_WIDTH-1:0]    sk_pc_q, sk_pc_d;

  logic       pop, push, issue;
  logic [1:0] occ;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    infl_d    = 1'b0;
    tag_d     = tag_q;
    hd_v_d    = hd_v_q;
    hd_data_d = hd_data_q;
    hd_pc_d   = hd_pc_q;
    sk_v_d    = sk_v_q;
    sk_data_d = sk_data_q;
    sk_pc_d   = sk_pc_q;

    pop  = hd_v_q & instr_ready;
    push = infl_q & ~redirect;
    occ  = {1'b0, hd_v_q} + {1'b0, sk_v_q} + {1'b0, infl_q};
    // A slot freed by this cycle's pop counts as available, sustaining 1 instr/cycle.
    issue = (state_q == S_RUN) & ~halt_req & ~redirect & ((occ - {1'b0, pop}) < 2'd2);

    case (state_q)
      S_IDLE:    if (start) state_d = S_RUN;
      S_RUN:     if (halt_req) state_d = S_HALTED;
      S_HALTED:  if (start && !halt_req) state_d = S_RUN;
      default:   state_d = S_IDLE;
    endcase

    if (redirect)   pc_d = redirect_pc;
    else if (issue) pc_d = pc_q + 1'b1;

    infl_d = issue;
    if (issue) tag_d = pc_q;

    if (redirect) begin
      hd_v_d = 1'b0;
      sk_v_d = 1'b0;
    end else if (pop && push) begin
      if (sk_v_q) begin
        hd_data_d = sk_data_q;
        hd_pc_d   = sk_pc_q;
        sk_data_d = imem_dout;
        sk_pc_d   = tag_q;
      end else begin
        hd_data_d = imem_dout;
        hd_pc_d   = tag_q;
      end
    end else if (pop) begin
      if (sk_v_q) begin
        hd_data_d = sk_data_q;
        hd_pc_d   = sk_pc_q;
        sk_v_d    = 1'b0;
      end else begin
        hd_v_d = 1'b0;
      end
    end else if (push) begin
      if (!hd_v_q) begin
        hd_v_d    = 1'b1;
        hd_data_d = imem_dout;
        hd_pc_d   = tag_q;
      end else begin
        sk_v_d    = 1'b1;
        sk_data_d = imem_dout;
        sk_pc_d   = tag_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      tag_q     <= '0;
      hd_v_q    <= 1'b0;
      hd_data_q <= '0;
      hd_pc_q   <= '0;
      sk_v_q    <= 1'b0;
      sk_data_q <= '0;
      sk_pc_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      tag_q     <= tag_d;
      hd_v_q    <= hd_v_d;
      hd_data_q <= hd_data_d;
      hd_pc_q   <= hd_pc_d;
      sk_v_q    <= sk_v_d;
      sk_data_q <= sk_data_d;
      sk_pc_q   <= sk_pc_d;
    end
  end

  assign imem_addr   = pc_q;
  assign imem_rd_en  = issue;
  assign instr_out   = hd_data_q;
  assign instr_pc    = hd_pc_q;
  assign instr_valid = hd_v_q;
  assign halted      = (state_q == S_HALTED);

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + 32'd1;
      if (hd_v_q && !instr_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
